// File: rtl/hazard_controller_pkg.sv
// Shared pipeline-control definitions: FSM state encoding and FwdRisk bit
// positions, common to hazard_controller and forwarding_unit.
package hazard_controller_pkg;

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_REDIRECT = 2'd2;

  typedef enum logic [1:0] {
    stRun      = S_RUN,
    stMemWait  = S_MEM_WAIT,
    stRedirect = S_REDIRECT
  } hazState_t;

  // Bit positions inside the 3-bit FwdRisk field
  localparam int RISK_RS1 = 2;
  localparam int RISK_RS2 = 1;
  localparam int RISK_RD  = 0;

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable and
// the count holds once it reaches all-ones.
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] q
);

  // Count up on enable, stop at all-ones, clear has priority
  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (en && (q != {CNT_WIDTH{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: freezes on data-memory
// wait states, flushes wrong-path fetches after a taken branch/jump and
// inserts a one-cycle bubble for load-use hazards forwarding cannot cover.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           ID_FwdRisk,
  input  logic [4:0]           ID_rs1,
  input  logic [4:0]           ID_rs2,
  input  logic [4:0]           EX_rd,
  input  logic                 EX_MemRead,
  input  logic                 EX_BrTaken,
  input  logic                 MEM_Req,
  input  logic                 MEM_Ack,
  output logic                 PC_En,
  output logic                 IFID_En,
  output logic                 IFID_Flush,
  output logic                 IDEX_En,
  output logic                 IDEX_Flush,
  output logic                 EXMEM_En,
  output logic                 MEMWB_Flush,
  output logic [CNT_WIDTH-1:0] StallCnt,
  output logic [CNT_WIDTH-1:0] FlushCnt
);

  localparam int                RCNT_W    = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [RCNT_W-1:0] RCNT_LOAD = RCNT_W'(FLUSH_CYCLES - 1);

  hazState_t         state, stateNext;
  hazState_t         retState, retStateNext;
  logic [RCNT_W-1:0] rcnt, rcntNext;
  logic              memWait;
  logic              loadUse;
  logic              branchTake;
  logic              unusedRdRisk;

  // The rd-write risk bit only matters to forwarding, not to stalling
  assign unusedRdRisk = ID_FwdRisk[RISK_RD];

  assign memWait = MEM_Req & ~MEM_Ack;

  // Load in EX feeding a source of the instruction in ID; x0 never conflicts
  assign loadUse = EX_MemRead && (EX_rd != 5'd0) &&
                   ((ID_FwdRisk[RISK_RS1] && (ID_rs1 == EX_rd)) ||
                    (ID_FwdRisk[RISK_RS2] && (ID_rs2 == EX_rd)));

  // State, return state and redirect countdown registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= stRun;
      retState <= stRun;
      rcnt     <= '0;
    end else begin
      state    <= stateNext;
      retState <= retStateNext;
      rcnt     <= rcntNext;
    end
  end

  // Next-state and stage-control decode, priority memwait > branch > load-use
  always_comb begin
    PC_En        = 1'b1;
    IFID_En      = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_En      = 1'b1;
    IDEX_Flush   = 1'b0;
    EXMEM_En     = 1'b1;
    MEMWB_Flush  = 1'b0;
    stateNext    = state;
    retStateNext = retState;
    rcntNext     = rcnt;
    branchTake   = 1'b0;

    if (state == stMemWait) begin
      // Frozen through the ack cycle; resume where the freeze started
      PC_En       = 1'b0;
      IFID_En     = 1'b0;
      IDEX_En     = 1'b0;
      EXMEM_En    = 1'b0;
      MEMWB_Flush = 1'b1;
      if (!memWait) stateNext = retState;
    end else if (memWait) begin
      PC_En        = 1'b0;
      IFID_En      = 1'b0;
      IDEX_En      = 1'b0;
      EXMEM_En     = 1'b0;
      MEMWB_Flush  = 1'b1;
      retStateNext = (state == stRedirect) ? stRedirect : stRun;
      stateNext    = stMemWait;
    end else if (EX_BrTaken) begin
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
      branchTake = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        stateNext = stRedirect;
        rcntNext  = RCNT_LOAD;
      end else begin
        stateNext = stRun;
      end
    end else if (state == stRedirect) begin
      // ID holds a bubble here, so load-use cannot apply
      IFID_Flush = 1'b1;
      rcntNext   = rcnt - RCNT_W'(1);
      if (rcnt <= RCNT_W'(1)) stateNext = stRun;
    end else if (loadUse) begin
      PC_En      = 1'b0;
      IFID_En    = 1'b0;
      IDEX_Flush = 1'b1;
    end

    if (!rst_n) begin
      PC_En       = 1'b0;
      IFID_En     = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_En     = 1'b0;
      IDEX_Flush  = 1'b1;
      EXMEM_En    = 1'b0;
      MEMWB_Flush = 1'b1;
      branchTake  = 1'b0;
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) uStallCnt (
    .clk   (clk),
    .en    (~PC_En & rst_n),
    .clear (~rst_n),
    .q     (StallCnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) uFlushCnt (
    .clk   (clk),
    .en    (branchTake),
    .clear (~rst_n),
    .q     (FlushCnt)
  );

endmodule
